// File: rtl/dac_spi_sequencer_if.sv
// Bus between the DAC command sequencer, its command ROM and the 3-wire DAC pins.
// The master side is the sequencer; the slave side is the ROM/DAC environment.
interface dac_spi_sequencer_if;
  logic        start;
  logic [3:0]  rom_addr;
  logic [23:0] rom_data;
  logic        sclk;
  logic        sync_n;
  logic        din;
  logic        busy;
  logic        done;
  logic        init_done;

  modport master (
    input  start, rom_data,
    output rom_addr, sclk, sync_n, din, busy, done, init_done
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, sclk, sync_n, din, busy, done, init_done
  );
endinterface

// File: rtl/dac_spi_sequencer.sv
// Walks the command ROM and shifts each 24-bit word MSB-first to a 3-wire DAC.
// Init words go out once after reset; each start request sends the channel words.
module dac_spi_sequencer #(
  parameter int CLK_DIV    = 2,
  parameter int NUM_INIT   = 2,
  parameter int NUM_WORDS  = 6,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dac_spi_sequencer_if.master   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       INIT_LAST  = 4'(NUM_INIT - 1);
  localparam logic [3:0]       CHAN_FIRST = 4'(NUM_INIT);
  localparam logic [3:0]       CHAN_LAST  = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT_HI, SHIFT_LO, GAP, FIN} state_t;

  state_t             state_reg;
  logic [3:0]         addr_reg;
  logic [23:0]        shreg_reg;
  logic [4:0]         bit_cnt_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               fetch_cnt_reg;
  logic               sclk_reg;
  logic               sync_n_reg;
  logic               din_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               init_done_reg;
  logic               pending_reg;
  logic               init_seq_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      fetch_cnt_reg <= 1'b0;
      sclk_reg      <= 1'b1;
      sync_n_reg    <= 1'b1;
      din_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      init_done_reg <= 1'b0;
      pending_reg   <= 1'b0;
      init_seq_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      // A start that cannot be serviced right now is remembered once; extras are dropped.
      if (bus.start && (busy_reg || !init_done_reg))
        pending_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (!init_done_reg) begin
            addr_reg      <= '0;
            init_seq_reg  <= 1'b1;
            busy_reg      <= 1'b1;
            fetch_cnt_reg <= 1'b0;
            state_reg     <= FETCH;
          end else if (bus.start || pending_reg) begin
            addr_reg      <= CHAN_FIRST;
            init_seq_reg  <= 1'b0;
            pending_reg   <= 1'b0;
            busy_reg      <= 1'b1;
            fetch_cnt_reg <= 1'b0;
            state_reg     <= FETCH;
          end
        end
        // Two cycles cover the ROM's registered read path.
        FETCH: begin
          fetch_cnt_reg <= 1'b1;
          if (fetch_cnt_reg)
            state_reg <= LOAD;
        end
        LOAD: begin
          shreg_reg   <= bus.rom_data;
          din_reg     <= bus.rom_data[23];
          sync_n_reg  <= 1'b0;
          bit_cnt_reg <= 5'd23;
          div_cnt_reg <= '0;
          state_reg   <= SHIFT_HI;
        end
        SHIFT_HI: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            state_reg   <= SHIFT_LO;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        SHIFT_LO: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b1;
            if (bit_cnt_reg != 5'd0) begin
              shreg_reg   <= shreg_reg << 1;
              din_reg     <= shreg_reg[22];
              bit_cnt_reg <= bit_cnt_reg - 5'd1;
              state_reg   <= SHIFT_HI;
            end else begin
              // Frame closes on the same edge as the final sclk rise.
              sync_n_reg  <= 1'b1;
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            if (addr_reg == (init_seq_reg ? INIT_LAST : CHAN_LAST)) begin
              state_reg <= FIN;
            end else begin
              addr_reg      <= addr_reg + 4'd1;
              fetch_cnt_reg <= 1'b0;
              state_reg     <= FETCH;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        FIN: begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          if (init_seq_reg)
            init_done_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr  = addr_reg;
  assign bus.sclk      = sclk_reg;
  assign bus.sync_n    = sync_n_reg;
  assign bus.din       = din_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.init_done = init_done_reg;

endmodule

// File: tb/tb_dac_spi_sequencer.sv
// Bench for dac_spi_sequencer: a ROM model feeds two instances (default and fastest timing);
// frame monitors capture din on falling sclk and compare against expected-word queues.
module tb_dac_spi_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  dac_spi_sequencer_if bus_a ();
  dac_spi_sequencer_if bus_b ();

  dac_spi_sequencer #(.CLK_DIV(2), .NUM_INIT(2), .NUM_WORDS(6), .GAP_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.master)
  );

  dac_spi_sequencer #(.CLK_DIV(1), .NUM_INIT(2), .NUM_WORDS(6), .GAP_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.master)
  );

  // ROM with a two-stage registered read: data valid 2 clk after an address change
  logic [23:0] rom [0:15];
  logic [3:0]  addr_q_a = 4'd0;
  logic [3:0]  addr_q_b = 4'd0;

  always @(posedge clk) begin
    addr_q_a      <= bus_a.rom_addr;
    bus_a.rom_data <= rom[addr_q_a];
    addr_q_b      <= bus_b.rom_addr;
    bus_b.rom_data <= rom[addr_q_b];
  end

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];

  // Monitor A
  logic        prev_sclk_a = 1'b1, prev_sync_a = 1'b1, act_a = 1'b0;
  logic [23:0] cap_a = '0, ew_a;
  int          falls_a = 0, frames_a = 0, done_cnt_a = 0;

  always @(negedge clk) begin
    if (!rst_n_a) begin
      act_a       = 1'b0;
      prev_sclk_a = 1'b1;
      prev_sync_a = 1'b1;
    end else begin
      if (prev_sync_a && !bus_a.sync_n) begin
        act_a = 1'b1; cap_a = '0; falls_a = 0;
      end
      if (prev_sclk_a && !bus_a.sclk) begin
        compared++;
        if (bus_a.sync_n !== 1'b0) begin
          mismatched++;
          $display("FAIL a_fall_in_frame: sync_n=%b required 0", bus_a.sync_n);
        end else begin
          cap_a = {cap_a[22:0], bus_a.din};
          falls_a++;
        end
      end
      if (!prev_sync_a && bus_a.sync_n && act_a) begin
        act_a = 1'b0;
        frames_a++;
        compared++;
        if (falls_a !== 24) begin
          mismatched++;
          $display("FAIL a_falls_per_frame: got %0d required 24", falls_a);
        end
        compared++;
        if (exp_a.size() == 0) begin
          mismatched++;
          $display("FAIL a_unexpected_frame: got %06h required no frame", cap_a);
        end else begin
          ew_a = exp_a.pop_front();
          $display("a frame %0d: got %06h expected %06h", frames_a, cap_a, ew_a);
          if (cap_a !== ew_a) begin
            mismatched++;
            $display("FAIL a_frame_word: got %06h required %06h", cap_a, ew_a);
          end
        end
      end
      if (bus_a.done === 1'b1) done_cnt_a++;
      prev_sclk_a = bus_a.sclk;
      prev_sync_a = bus_a.sync_n;
    end
  end

  // Monitor B: also checks sclk phase lengths and word period
  logic        prev_sclk_b = 1'b1, prev_sync_b = 1'b1, act_b = 1'b0, run_ok_b = 1'b0, pf_ok_b = 1'b0;
  logic [23:0] cap_b = '0, ew_b;
  int          falls_b = 0, frames_b = 0, done_cnt_b = 0, run_b = 0, cyc_b = 0, pf_b = 0;

  always @(negedge clk) begin
    cyc_b++;
    if (!rst_n_b) begin
      act_b = 1'b0; pf_ok_b = 1'b0;
      prev_sclk_b = 1'b1;
      prev_sync_b = 1'b1;
    end else begin
      if (prev_sync_b && !bus_b.sync_n) begin
        act_b = 1'b1; cap_b = '0; falls_b = 0; run_ok_b = 1'b0; run_b = 0;
        if (pf_ok_b) begin
          compared++;
          if (cyc_b - pf_b !== 52) begin
            mismatched++;
            $display("FAIL b_word_period: got %0d required 52", cyc_b - pf_b);
          end
        end
        pf_b = cyc_b; pf_ok_b = 1'b1;
      end
      if (act_b && !bus_b.sync_n) begin
        if (bus_b.sclk !== prev_sclk_b) begin
          if (run_ok_b) begin
            compared++;
            if (run_b !== 1) begin
              mismatched++;
              $display("FAIL b_sclk_phase_len: got %0d required 1", run_b);
            end
          end
          run_ok_b = 1'b1; run_b = 1;
        end else begin
          run_b++;
        end
      end
      if (prev_sclk_b && !bus_b.sclk) begin
        compared++;
        if (bus_b.sync_n !== 1'b0) begin
          mismatched++;
          $display("FAIL b_fall_in_frame: sync_n=%b required 0", bus_b.sync_n);
        end else begin
          cap_b = {cap_b[22:0], bus_b.din};
          falls_b++;
        end
      end
      if (!prev_sync_b && bus_b.sync_n && act_b) begin
        act_b = 1'b0;
        frames_b++;
        compared++;
        if (falls_b !== 24) begin
          mismatched++;
          $display("FAIL b_falls_per_frame: got %0d required 24", falls_b);
        end
        compared++;
        if (exp_b.size() == 0) begin
          mismatched++;
          $display("FAIL b_unexpected_frame: got %06h required no frame", cap_b);
        end else begin
          ew_b = exp_b.pop_front();
          $display("b frame %0d: got %06h expected %06h", frames_b, cap_b, ew_b);
          if (cap_b !== ew_b) begin
            mismatched++;
            $display("FAIL b_frame_word: got %06h required %06h", cap_b, ew_b);
          end
        end
      end
      if (bus_b.done === 1'b1) begin
        done_cnt_b++;
        pf_ok_b = 1'b0;
      end
      prev_sclk_b = bus_b.sclk;
      prev_sync_b = bus_b.sync_n;
    end
  end

  task automatic wait_done_a(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt_a >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_b(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt_b >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
  endtask

  task automatic push_init_a();
    exp_a.push_back(24'h280001);
    exp_a.push_back(24'h373FF0);
  endtask

  task automatic push_chan_a();
    exp_a.push_back(24'h001100);
    exp_a.push_back(24'h012200);
    exp_a.push_back(24'h023300);
    exp_a.push_back(24'h134400);
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst_n_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus_a.start = 1'b1;          // start together with reset must be lost
    @(posedge clk); #1 bus_a.start = 1'b0;
    @(negedge clk);
    got = {bus_a.rom_addr, bus_a.sclk, bus_a.sync_n, bus_a.din, bus_a.busy, bus_a.done, bus_a.init_done};
    compared++;
    if (got !== 10'b0000_110000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b required %b", got, 10'b0000_110000);
    end
  endtask

  task automatic test_init();
    bit ok;
    int base;
    base = done_cnt_a;
    push_init_a();
    @(posedge clk); #1 rst_n_a = 1'b1;
    @(posedge clk); @(negedge clk);
    compared++;
    if (bus_a.busy !== 1'b1) begin
      mismatched++; $display("FAIL init_busy_start: got %b required 1", bus_a.busy);
    end
    wait_done_a(base + 1, 2000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL init_done_timeout: got no done required done"); end
    @(negedge clk);
    compared++;
    if (bus_a.init_done !== 1'b1) begin
      mismatched++; $display("FAIL init_done_level: got %b required 1", bus_a.init_done);
    end
    repeat (400) @(negedge clk);
    compared++;
    if (done_cnt_a !== base + 1 || exp_a.size() != 0 || bus_a.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL init_quiet_after: done=%0d left=%0d busy=%b required done=%0d left=0 busy=0",
               done_cnt_a, exp_a.size(), bus_a.busy, base + 1);
    end
  endtask

  task automatic test_channel();
    bit ok;
    int base;
    base = done_cnt_a;
    push_chan_a();
    pulse_start_a();
    wait_done_a(base + 1, 3000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL channel_timeout: got no done required done"); end
    repeat (50) @(negedge clk);
    compared++;
    if (exp_a.size() != 0 || done_cnt_a !== base + 1) begin
      mismatched++;
      $display("FAIL channel_frames: left=%0d done=%0d required left=0 done=%0d", exp_a.size(), done_cnt_a, base + 1);
    end
    compared++;
    if (bus_a.rom_addr !== 4'd5) begin
      mismatched++; $display("FAIL channel_addr_hold: got %0d required 5", bus_a.rom_addr);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    base = done_cnt_a;
    push_chan_a();
    push_chan_a();
    pulse_start_a();
    repeat (150) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_start_a();
      repeat (5) @(posedge clk);
    end
    wait_done_a(base + 1, 3000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL b2b_first_timeout: got no done required done"); end
    @(negedge clk);
    compared++;
    if (bus_a.busy !== 1'b1) begin
      mismatched++; $display("FAIL b2b_busy_resume: got %b required 1", bus_a.busy);
    end
    repeat (200) @(negedge clk);
    compared++;
    if (bus_a.busy !== 1'b1) begin
      mismatched++; $display("FAIL b2b_busy_mid: got %b required 1", bus_a.busy);
    end
    wait_done_a(base + 2, 3000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL b2b_second_timeout: got no done required done"); end
    repeat (600) @(negedge clk);
    compared++;
    if (done_cnt_a !== base + 2 || exp_a.size() != 0 || bus_a.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_exactly_one_extra: done=%0d left=%0d busy=%b required done=%0d left=0 busy=0",
               done_cnt_a, exp_a.size(), bus_a.busy, base + 2);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int base;
    pulse_start_a();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (act_a && falls_a >= 11) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL midreset_reach_bit: got falls=%0d required 11", falls_a); end
    #1 rst_n_a = 1'b0;
    @(posedge clk); @(negedge clk);
    compared++;
    if ({bus_a.sync_n, bus_a.sclk, bus_a.busy, bus_a.init_done} !== 4'b1100) begin
      mismatched++;
      $display("FAIL midreset_outputs: sync_n,sclk,busy,init_done=%b required 1100",
               {bus_a.sync_n, bus_a.sclk, bus_a.busy, bus_a.init_done});
    end
    repeat (2) @(posedge clk);
    base = done_cnt_a;
    push_init_a();
    #1 rst_n_a = 1'b1;
    wait_done_a(base + 1, 2000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL midreset_init_timeout: got no done required done"); end
    repeat (400) @(negedge clk);
    compared++;
    if (exp_a.size() != 0 || done_cnt_a !== base + 1 || bus_a.init_done !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_replay: left=%0d done=%0d init_done=%b required left=0 done=%0d init_done=1",
               exp_a.size(), done_cnt_a, bus_a.init_done, base + 1);
    end
  endtask

  task automatic test_start_before_init();
    bit ok;
    int base;
    @(posedge clk); #1 rst_n_a = 1'b0;
    repeat (3) @(posedge clk);
    base = done_cnt_a;
    push_init_a();
    push_chan_a();
    #1 rst_n_a = 1'b1;
    repeat (5) @(posedge clk);
    pulse_start_a();
    wait_done_a(base + 2, 4000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL early_start_timeout: done=%0d required %0d", done_cnt_a, base + 2); end
    repeat (600) @(negedge clk);
    compared++;
    if (exp_a.size() != 0 || done_cnt_a !== base + 2) begin
      mismatched++;
      $display("FAIL early_start_sequence: left=%0d done=%0d required left=0 done=%0d",
               exp_a.size(), done_cnt_a, base + 2);
    end
  endtask

  task automatic test_fast_timing();
    bit ok;
    int base;
    base = done_cnt_b;
    exp_b.push_back(24'h280001);
    exp_b.push_back(24'h373FF0);
    @(posedge clk); #1 rst_n_b = 1'b1;
    wait_done_b(base + 1, 1000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL fast_init_timeout: got no done required done"); end
    exp_b.push_back(24'h001100);
    exp_b.push_back(24'h012200);
    exp_b.push_back(24'h023300);
    exp_b.push_back(24'h134400);
    @(posedge clk); #1 bus_b.start = 1'b1;
    @(posedge clk); #1 bus_b.start = 1'b0;
    wait_done_b(base + 2, 1000, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL fast_chan_timeout: got no done required done"); end
    repeat (50) @(negedge clk);
    compared++;
    if (exp_b.size() != 0 || frames_b !== 6) begin
      mismatched++;
      $display("FAIL fast_frames: left=%0d frames=%0d required left=0 frames=6", exp_b.size(), frames_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
    rom[0] = 24'h280001;
    rom[1] = 24'h373FF0;
    rom[2] = 24'h001100;
    rom[3] = 24'h012200;
    rom[4] = 24'h023300;
    rom[5] = 24'h134400;
    rst_n_a     = 1'b0;
    rst_n_b     = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    test_reset();
    test_init();
    test_channel();
    test_back_to_back();
    test_reset_midframe();
    test_start_before_init();
    test_fast_timing();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
